// File: rtl/tile_addr_gen.sv
// tile_addr_gen
//   Generates the row-major element address stream for one matrix tile load.
//   A start in IDLE latches the tile geometry; the block then presents one
//   address beat at a time on a valid/ready port and steps to the next element
//   only when that beat is accepted. cnt_enable mirrors every accepted beat
//   so a downstream beat counter advances once per transfer.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             launch request, only looked at in IDLE
//   base_addr         address of element (0,0)
//   row_stride        address delta between consecutive rows
//   num_rows/num_cols tile geometry; a zero dimension completes with no beats
//   busy              high while beats are being issued (RUN)
//   done              one-cycle completion pulse (DONE)
//   out_valid/ready   address beat handshake
//   out_addr/row/col  current element address and indices
//   out_last          marks the final beat of the tile
//   cnt_enable        out_valid & out_ready, drives the beat counter enable
//
// Handshake: a beat transfers on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_addr, out_row, out_col and out_last hold their values; out_valid never
// drops until the beat it qualifies has been accepted.

module tile_addr_gen #(
  parameter int ROW_W  = 8,
  parameter int COL_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [COL_W-1:0]  num_cols,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_last,
  output logic              cnt_enable
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Geometry captured at launch; the live inputs are ignored afterwards.
  logic [ADDR_W-1:0] stride_q;
  logic [ROW_W-1:0]  rows_q;
  logic [COL_W-1:0]  cols_q;
  // Address of column 0 of the current row; stepping rows only needs an add.
  logic [ADDR_W-1:0] row_base;

  logic accept;
  logic last_col;
  logic last_row;

  // Status outputs decode straight from the state register, so they are
  // glitch-free and change only on clock edges.
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign out_valid  = (state == RUN);

  assign accept     = out_valid & out_ready;
  assign cnt_enable = accept;

  // cols_q/rows_q are never zero in RUN, so the minus-one cannot underflow
  // while these compares matter.
  assign last_col   = (out_col == cols_q - COL_W'(1));
  assign last_row   = (out_row == rows_q - ROW_W'(1));
  assign out_last   = out_valid & last_row & last_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out_addr <= '0;
      out_row  <= '0;
      out_col  <= '0;
      stride_q <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      row_base <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if ((num_rows != '0) && (num_cols != '0)) begin
              stride_q <= row_stride;
              rows_q   <= num_rows;
              cols_q   <= num_cols;
              row_base <= base_addr;
              out_addr <= base_addr;
              out_row  <= '0;
              out_col  <= '0;
              state    <= RUN;
            end else begin
              // Empty tile: report completion without issuing any beat.
              state <= DONE;
            end
          end
        end

        RUN: begin
          if (accept) begin
            if (!last_col) begin
              out_col  <= out_col + COL_W'(1);
              out_addr <= out_addr + ADDR_W'(1);
            end else if (!last_row) begin
              out_col  <= '0;
              out_row  <= out_row + ROW_W'(1);
              row_base <= row_base + stride_q;
              out_addr <= row_base + stride_q;
            end else begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_addr_gen.sv
// Directed testbench for tile_addr_gen. Inputs change on the falling edge,
// outputs are checked on the falling edge (after a #1 settle when an input
// was just changed), and the DUT captures on the rising edge.

module tb_tile_addr_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] row_stride;
  logic [7:0]  num_rows;
  logic [7:0]  num_cols;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_addr;
  logic [7:0]  out_row;
  logic [7:0]  out_col;
  logic        out_last;
  logic        cnt_enable;

  int n_cmp;
  int n_bad;
  int beat_cnt;   // models the downstream beat counter
  int done_cnt;

  tile_addr_gen #(.ROW_W(8), .COL_W(8), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .num_rows   (num_rows),
    .num_cols   (num_cols),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .cnt_enable (cnt_enable)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_enable === 1'b1) beat_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic apply_reset();
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    base_addr = '0;
    row_stride = '0;
    num_rows = '0;
    num_cols = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Presents start for one rising edge, then scrambles the geometry inputs so
  // any use of live (unlatched) inputs shows up as wrong addresses.
  task automatic start_tile(input logic [15:0] base, input logic [15:0] stride,
                            input int rows, input int cols);
    base_addr  = base;
    row_stride = stride;
    num_rows   = 8'(rows);
    num_cols   = 8'(cols);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    base_addr  = 16'($urandom_range(0, 65535));
    row_stride = 16'($urandom_range(0, 65535));
    num_rows   = 8'($urandom_range(1, 255));
    num_cols   = 8'($urandom_range(1, 255));
  endtask

  // Runs one tile and checks every presented beat against an independent
  // row*stride+col model; optional stall (ready low) on beat stall_at, and
  // optional start pokes during RUN and during the DONE cycle.
  task automatic run_tile(input string name, input logic [15:0] base,
                          input logic [15:0] stride, input int rows, input int cols,
                          input int stall_at, input int stall_len, input bit poke);
    int total;
    int idx;
    int stall;
    int en0;
    int r;
    int c;
    logic [33:0] got;
    logic [33:0] exp;
    total = rows * cols;
    idx   = 0;
    stall = 0;
    en0   = beat_cnt;
    start_tile(base, stride, rows, cols);
    for (int cyc = 0; cyc < total + stall_len + 2 && idx < total; cyc++) begin
      out_ready = (idx == stall_at && stall < stall_len) ? 1'b0 : 1'b1;
      start     = poke && (cyc == 1);
      #1;
      r   = idx / cols;
      c   = idx % cols;
      exp = {1'b1, (idx == total - 1), 8'(r), 8'(c), 16'(base + 16'(r) * stride + 16'(c))};
      got = {out_valid, out_last, out_row, out_col, out_addr};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s beat %0d: got v/last/row/col/addr=%h required %h", name, idx, got, exp);
      end
      n_cmp++;
      if (cnt_enable !== out_ready) begin
        n_bad++;
        $display("FAIL %s cnt_enable beat %0d: got %b required %b", name, idx, cnt_enable, out_ready);
      end
      if (out_ready) idx++;
      else stall++;
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if ({done, busy, out_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL %s done cycle: got done/busy/valid=%b required 100", name, {done, busy, out_valid});
    end
    // A start during the DONE cycle must be ignored.
    if (poke) begin
      base_addr = 16'h0500;
      num_rows  = 8'd1;
      num_cols  = 8'd1;
      start     = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({done, busy, out_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL %s after done: got done/busy/valid=%b required 000", name, {done, busy, out_valid});
    end
    n_cmp++;
    if (beat_cnt - en0 !== total) begin
      n_bad++;
      $display("FAIL %s beat count: got %0d required %0d", name, beat_cnt - en0, total);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, out_valid, out_last, cnt_enable} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset flags: got %b required 00000", {busy, done, out_valid, out_last, cnt_enable});
    end
    n_cmp++;
    if ({out_addr, out_row, out_col} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset addr/row/col: got %h required 00000000", {out_addr, out_row, out_col});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int d0;
    d0 = done_cnt;
    run_tile("basic", 16'h0100, 16'h0010, 2, 3, -1, 0, 1'b0);
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL basic done pulses: got %0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    run_tile("backpressure", 16'h0100, 16'h0010, 2, 3, 1, 3, 1'b0);
  endtask

  task automatic test_zero_dim();
    int e0;
    int d0;
    e0 = beat_cnt;
    d0 = done_cnt;
    start_tile(16'h0300, 16'h0010, 0, 4);
    n_cmp++;
    if ({done, busy, out_valid, cnt_enable} !== 4'b1000) begin
      n_bad++;
      $display("FAIL zero_dim done cycle: got done/busy/valid/en=%b required 1000", {done, busy, out_valid, cnt_enable});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({done, out_valid} !== 2'b00) begin
        n_bad++;
        $display("FAIL zero_dim idle %0d: got done/valid=%b required 00", i, {done, out_valid});
      end
    end
    n_cmp++;
    if ((beat_cnt - e0) !== 0 || (done_cnt - d0) !== 1) begin
      n_bad++;
      $display("FAIL zero_dim counts: got beats=%0d dones=%0d required 0 and 1", beat_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    run_tile("wrap_cols", 16'hFFFE, 16'h0000, 1, 4, -1, 0, 1'b0);
    run_tile("wrap_rows", 16'h9000, 16'h8000, 2, 1, -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int d0;
    start_tile(16'h0100, 16'h0010, 2, 3);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_addr !== 16'h0110) begin
      n_bad++;
      $display("FAIL midrun before reset: got addr %h required 0110", out_addr);
    end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, out_valid, out_last, cnt_enable, out_addr, out_row, out_col} !== 37'h0) begin
      n_bad++;
      $display("FAIL midrun reset outputs: got %h required 0", {busy, done, out_valid, out_last, cnt_enable, out_addr, out_row, out_col});
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if ((done_cnt - d0) !== 0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun no done: got dones=%0d valid=%b required 0 and 0", done_cnt - d0, out_valid);
    end
    run_tile("midrun_restart", 16'h0200, 16'h0020, 2, 3, -1, 0, 1'b0);
  endtask

  task automatic test_ignored_start();
    run_tile("ignored_start", 16'h0400, 16'h0008, 2, 2, -1, 0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({busy, out_valid, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL ignored_start idle: got busy/valid/done=%b required 000", {busy, out_valid, done});
    end
    run_tile("one_by_one", 16'h0ABC, 16'h0100, 1, 1, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Restart in the IDLE cycle right after DONE.
    run_tile("b2b_a", 16'h1000, 16'h0004, 1, 2, -1, 0, 1'b0);
    run_tile("b2b_b", 16'h2000, 16'h0010, 3, 2, 4, 2, 1'b0);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    beat_cnt = 0;
    done_cnt = 0;
    apply_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_dim();
    test_wrap();
    test_reset_mid_run();
    test_ignored_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
